id_decode: RTL and testbench
============================

# id_decode

Instruction-decode pipeline stage between fetch and execute. Captures a fetched 32-bit MIPS instruction and its PC under a valid/ready handshake, decodes it, and presents registered fields and controls to execute. Its `imm` and `sext` outputs drive the sign/zero immediate extender directly. Supports stall via backpressure and flush to a bubble.

## Interface

- IMM_WIDTH, 16, immediate field width; must equal the extender's WIDTH.
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  fetch offers an instruction
- in_ready  out  1  stage can accept this cycle
- in_pc  in  32  PC of offered instruction
- in_instr  in  32  offered instruction word
- flush  in  1  discard held and offered instruction (branch taken)
- out_valid  out  1  decoded instruction held
- out_ready  in  1  execute consumes this cycle
- out_pc  out  32  registered PC
- rs, rt  out  5  source register addresses
- wb_addr  out  5  destination register (rd / rt / 31)
- shamt  out  5  shift amount
- imm  out  IMM_WIDTH  instr[15:0]
- sext  out  1  1 = sign-extend imm, 0 = zero-extend
- alu_op  out  4  ALU operation code
- reg_write, mem_read, mem_write, branch_eq, branch_ne, jump, jump_reg  out  1 each  controls
- jidx  out  26  jump index instr[25:0]
- illegal  out  1  unsupported opcode/funct

## Operation

- in_ready = !out_valid || out_ready (combinational; no skid buffer).
- Load when in_valid && in_ready && !flush: all outputs take the decode of in_instr, out_valid <= 1.
- Else if out_ready && out_valid (or flush): out_valid <= 0. Fields hold their last values; only out_valid signals validity.
- flush has priority over load and hold. The offered instruction is dropped, so fetch must treat flush as a consumed beat.
- R-type (op 0x00): add 20, addu 21, sub 22, subu 23, and 24, or 25, xor 26, nor 27, slt 2A, sltu 2B, sll 00, srl 02, sra 03, jr 08. wb_addr = rd. reg_write = 1, except jr: jump_reg = 1, reg_write = 0.
- I-type, wb_addr = rt:
  - sext = 1: addi 08, addiu 09, slti 0A, sltiu 0B, lw 23 (mem_read), sw 2B (mem_write, no reg_write), beq 04, bne 05 (branch, alu_op SUB, no reg_write).
  - sext = 0: andi 0C, ori 0D, xori 0E, lui 0F (alu_op LUI).
- J-type: j 02 (jump); jal 03 (jump, reg_write, wb_addr = 31).
- Any other opcode/funct: illegal = 1, all write/mem/branch/jump controls 0. Still valid and still handshaken.
- instr = 0x00000000 decodes as sll $0,$0,0. This is a legal nop, illegal = 0.

## Timing

- Latency 1 cycle from accepted beat to out_valid. Throughput 1 per cycle while out_ready = 1.
- Reset (rst_n = 0 at edge) clears every output register to 0: out_valid = 0, out_pc = 0, fields 0, alu_op = ADD, sext = 0, illegal = 0. Reset overrides flush and load.
- Reset mid-stall discards the held instruction. in_ready = 1 on the first cycle after reset.
- Simultaneous consume and accept: the new beat replaces the held one in the same edge, with no bubble.
- out_valid && !out_ready: outputs stable, in_ready = 0.

## Structure

- Shared package `mips_pkg`:
  - opcode and funct localparams.
  - alu_op codes: ADD 0, SUB 1, AND 2, OR 3, XOR 4, NOR 5, SLT 6, SLTU 7, SLL 8, SRL 9, SRA 10, LUI 11.
  - Also used by the ALU.
- Natural sub-module `id_ctrl`: purely combinational opcode/funct to control-bundle decoder. `id_decode` holds the handshake and pipeline registers.

## Test plan

- Reset: hold rst_n = 0 two cycles with in_valid = 1 -> out_valid = 0, in_ready = 1, all outputs 0.
- Stream: 0x2008FFFF (addi $8,$0,-1), 0x3409FFFF (ori), 0x8D0A0004 (lw) with out_ready = 1. Each appears 1 cycle later:
  - addi: sext = 1, imm = FFFF, wb_addr = 8.
  - ori: sext = 0, wb_addr = 9.
  - lw: mem_read = 1, sext = 1.
- Backpressure: out_ready = 0 for 3 cycles with a valid held -> in_ready = 0, outputs unchanged. Release -> next beat loads with no gap.
- Flush: assert flush while holding jal 0x0C000010 and offering add -> out_valid = 0 next cycle, add not presented.
- Decode coverage:
  - 0x012A5820 (add $11) -> wb_addr = 11, reg_write = 1.
  - 0x03E00008 (jr) -> jump_reg = 1, reg_write = 0.
  - 0xFC000000 -> illegal = 1, no controls asserted.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg: shared MIPS-I encodings for the decode stage and the ALU.
// Holds opcode/funct numbers, the ALU operation codes, the destination
// select used by decode, and the control bundle produced by id_ctrl.
package mips_pkg;

    // Primary opcodes, instr[31:26]
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type function codes, instr[5:0]
    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    // Link register written by jal
    localparam logic [4:0] REG_RA = 5'd31;

    // ALU operation codes, shared with the execute-stage ALU
    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_NOR  = 4'd5,
        ALU_SLT  = 4'd6,
        ALU_SLTU = 4'd7,
        ALU_SLL  = 4'd8,
        ALU_SRL  = 4'd9,
        ALU_SRA  = 4'd10,
        ALU_LUI  = 4'd11
    } alu_op_e;

    // Which instruction field names the destination register
    typedef enum logic [1:0] {
        WB_RT = 2'd0,
        WB_RD = 2'd1,
        WB_RA = 2'd2
    } wb_sel_e;

    // Control bundle derived from opcode/funct alone
    typedef struct packed {
        alu_op_e alu_op;
        wb_sel_e wb_sel;
        logic    sext;
        logic    reg_write;
        logic    mem_read;
        logic    mem_write;
        logic    branch_eq;
        logic    branch_ne;
        logic    jump;
        logic    jump_reg;
        logic    illegal;
    } ctrl_t;

    // Everything off: the starting point for every decode
    localparam ctrl_t CTRL_NONE = '{
        alu_op:    ALU_ADD,
        wb_sel:    WB_RT,
        sext:      1'b0,
        reg_write: 1'b0,
        mem_read:  1'b0,
        mem_write: 1'b0,
        branch_eq: 1'b0,
        branch_ne: 1'b0,
        jump:      1'b0,
        jump_reg:  1'b0,
        illegal:   1'b0
    };

    function automatic logic [5:0] opcodeOf(input logic [31:0] instr);
        return instr[31:26];
    endfunction

    function automatic logic [5:0] functOf(input logic [31:0] instr);
        return instr[5:0];
    endfunction

endpackage

// File: rtl/id_decode_if.sv
// id_decode_if: fetch-side and execute-side handshake plus the decoded
// fields of the decode stage. The slave modport is the decode stage's view,
// the master modport is the view of whatever drives fetch and consumes
// execute (in practice the surrounding pipeline or a testbench).
interface id_decode_if #(
    parameter int IMM_WIDTH = 16
);
    // Fetch side
    logic                 in_valid;
    logic                 in_ready;
    logic [31:0]          in_pc;
    logic [31:0]          in_instr;
    logic                 flush;

    // Execute side
    logic                 out_valid;
    logic                 out_ready;
    logic [31:0]          out_pc;
    logic [4:0]           rs;
    logic [4:0]           rt;
    logic [4:0]           wb_addr;
    logic [4:0]           shamt;
    logic [IMM_WIDTH-1:0] imm;
    logic                 sext;
    logic [3:0]           alu_op;
    logic                 reg_write;
    logic                 mem_read;
    logic                 mem_write;
    logic                 branch_eq;
    logic                 branch_ne;
    logic                 jump;
    logic                 jump_reg;
    logic [25:0]          jidx;
    logic                 illegal;

    modport slave (
        input  in_valid, in_pc, in_instr, flush, out_ready,
        output in_ready, out_valid, out_pc, rs, rt, wb_addr, shamt, imm,
               sext, alu_op, reg_write, mem_read, mem_write, branch_eq,
               branch_ne, jump, jump_reg, jidx, illegal
    );

    modport master (
        output in_valid, in_pc, in_instr, flush, out_ready,
        input  in_ready, out_valid, out_pc, rs, rt, wb_addr, shamt, imm,
               sext, alu_op, reg_write, mem_read, mem_write, branch_eq,
               branch_ne, jump, jump_reg, jidx, illegal
    );

endinterface

// File: rtl/id_ctrl.sv
// id_ctrl: purely combinational opcode/funct to control-bundle decoder.
// Unsupported encodings come out with every write/memory/branch/jump
// control low and illegal set, so they flow down the pipe harmlessly.
module id_ctrl
    import mips_pkg::*;
(
    input  logic [5:0] i_opcode,
    input  logic [5:0] i_funct,
    output ctrl_t      o_ctrl
);

    // Decode opcode (and funct for R-type) into the control bundle
    always_comb begin
        o_ctrl = CTRL_NONE;
        case (i_opcode)
            OP_RTYPE: begin
                o_ctrl.wb_sel    = WB_RD;
                o_ctrl.reg_write = 1'b1;
                case (i_funct)
                    FN_ADD, FN_ADDU: o_ctrl.alu_op = ALU_ADD;
                    FN_SUB, FN_SUBU: o_ctrl.alu_op = ALU_SUB;
                    FN_AND:          o_ctrl.alu_op = ALU_AND;
                    FN_OR:           o_ctrl.alu_op = ALU_OR;
                    FN_XOR:          o_ctrl.alu_op = ALU_XOR;
                    FN_NOR:          o_ctrl.alu_op = ALU_NOR;
                    FN_SLT:          o_ctrl.alu_op = ALU_SLT;
                    FN_SLTU:         o_ctrl.alu_op = ALU_SLTU;
                    FN_SLL:          o_ctrl.alu_op = ALU_SLL;
                    FN_SRL:          o_ctrl.alu_op = ALU_SRL;
                    FN_SRA:          o_ctrl.alu_op = ALU_SRA;
                    FN_JR: begin
                        o_ctrl.reg_write = 1'b0;
                        o_ctrl.jump_reg  = 1'b1;
                    end
                    default: begin
                        o_ctrl.reg_write = 1'b0;
                        o_ctrl.illegal   = 1'b1;
                    end
                endcase
            end
            OP_ADDI, OP_ADDIU: begin
                o_ctrl.sext      = 1'b1;
                o_ctrl.reg_write = 1'b1;
                o_ctrl.alu_op    = ALU_ADD;
            end
            OP_SLTI: begin
                o_ctrl.sext      = 1'b1;
                o_ctrl.reg_write = 1'b1;
                o_ctrl.alu_op    = ALU_SLT;
            end
            OP_SLTIU: begin
                o_ctrl.sext      = 1'b1;
                o_ctrl.reg_write = 1'b1;
                o_ctrl.alu_op    = ALU_SLTU;
            end
            OP_LW: begin
                o_ctrl.sext      = 1'b1;
                o_ctrl.reg_write = 1'b1;
                o_ctrl.mem_read  = 1'b1;
                o_ctrl.alu_op    = ALU_ADD;
            end
            OP_SW: begin
                o_ctrl.sext      = 1'b1;
                o_ctrl.mem_write = 1'b1;
                o_ctrl.alu_op    = ALU_ADD;
            end
            OP_BEQ: begin
                o_ctrl.sext      = 1'b1;
                o_ctrl.branch_eq = 1'b1;
                o_ctrl.alu_op    = ALU_SUB;
            end
            OP_BNE: begin
                o_ctrl.sext      = 1'b1;
                o_ctrl.branch_ne = 1'b1;
                o_ctrl.alu_op    = ALU_SUB;
            end
            OP_ANDI: begin
                o_ctrl.reg_write = 1'b1;
                o_ctrl.alu_op    = ALU_AND;
            end
            OP_ORI: begin
                o_ctrl.reg_write = 1'b1;
                o_ctrl.alu_op    = ALU_OR;
            end
            OP_XORI: begin
                o_ctrl.reg_write = 1'b1;
                o_ctrl.alu_op    = ALU_XOR;
            end
            OP_LUI: begin
                o_ctrl.reg_write = 1'b1;
                o_ctrl.alu_op    = ALU_LUI;
            end
            OP_J: begin
                o_ctrl.jump = 1'b1;
            end
            OP_JAL: begin
                o_ctrl.jump      = 1'b1;
                o_ctrl.reg_write = 1'b1;
                o_ctrl.wb_sel    = WB_RA;
            end
            default: begin
                o_ctrl.illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/id_decode.sv
// id_decode: instruction-decode pipeline stage. Accepts one fetched
// instruction per cycle under valid/ready, decodes it through id_ctrl and
// holds the result in output registers until execute consumes it. There is
// no skid buffer, so in_ready depends combinationally on out_ready. A flush
// turns the stage into a bubble and drops whatever fetch is offering.
module id_decode
    import mips_pkg::*;
#(
    parameter int IMM_WIDTH = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    id_decode_if.slave bus
);

    logic [31:0]          w_instr;
    logic [5:0]           w_opcode;
    logic [5:0]           w_funct;
    ctrl_t                w_ctrl;
    logic [4:0]           w_wbAddr;
    logic                 w_inReady;
    logic                 w_load;

    logic                 r_valid;
    logic [31:0]          r_pc;
    logic [4:0]           r_rs;
    logic [4:0]           r_rt;
    logic [4:0]           r_wbAddr;
    logic [4:0]           r_shamt;
    logic [IMM_WIDTH-1:0] r_imm;
    logic                 r_sext;
    alu_op_e              r_aluOp;
    logic                 r_regWrite;
    logic                 r_memRead;
    logic                 r_memWrite;
    logic                 r_branchEq;
    logic                 r_branchNe;
    logic                 r_jump;
    logic                 r_jumpReg;
    logic [25:0]          r_jidx;
    logic                 r_illegal;

    assign w_instr  = bus.in_instr;
    assign w_opcode = opcodeOf(w_instr);
    assign w_funct  = functOf(w_instr);

    id_ctrl u_ctrl (
        .i_opcode (w_opcode),
        .i_funct  (w_funct),
        .o_ctrl   (w_ctrl)
    );

    // The stage can take a new beat when empty or when its beat leaves now
    assign w_inReady = !r_valid || bus.out_ready;
    assign w_load    = bus.in_valid && w_inReady && !bus.flush;

    // Pick the destination register field named by the control bundle
    always_comb begin
        w_wbAddr = w_instr[20:16];
        case (w_ctrl.wb_sel)
            WB_RD:   w_wbAddr = w_instr[15:11];
            WB_RA:   w_wbAddr = REG_RA;
            default: w_wbAddr = w_instr[20:16];
        endcase
    end

    // Pipeline register: reset beats flush, flush beats load, load beats drain
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid    <= 1'b0;
            r_pc       <= '0;
            r_rs       <= '0;
            r_rt       <= '0;
            r_wbAddr   <= '0;
            r_shamt    <= '0;
            r_imm      <= '0;
            r_sext     <= 1'b0;
            r_aluOp    <= ALU_ADD;
            r_regWrite <= 1'b0;
            r_memRead  <= 1'b0;
            r_memWrite <= 1'b0;
            r_branchEq <= 1'b0;
            r_branchNe <= 1'b0;
            r_jump     <= 1'b0;
            r_jumpReg  <= 1'b0;
            r_jidx     <= '0;
            r_illegal  <= 1'b0;
        end else if (bus.flush) begin
            r_valid <= 1'b0;
        end else if (w_load) begin
            r_valid    <= 1'b1;
            r_pc       <= bus.in_pc;
            r_rs       <= w_instr[25:21];
            r_rt       <= w_instr[20:16];
            r_wbAddr   <= w_wbAddr;
            r_shamt    <= w_instr[10:6];
            r_imm      <= w_instr[IMM_WIDTH-1:0];
            r_sext     <= w_ctrl.sext;
            r_aluOp    <= w_ctrl.alu_op;
            r_regWrite <= w_ctrl.reg_write;
            r_memRead  <= w_ctrl.mem_read;
            r_memWrite <= w_ctrl.mem_write;
            r_branchEq <= w_ctrl.branch_eq;
            r_branchNe <= w_ctrl.branch_ne;
            r_jump     <= w_ctrl.jump;
            r_jumpReg  <= w_ctrl.jump_reg;
            r_jidx     <= w_instr[25:0];
            r_illegal  <= w_ctrl.illegal;
        end else if (bus.out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign bus.in_ready  = w_inReady;
    assign bus.out_valid = r_valid;
    assign bus.out_pc    = r_pc;
    assign bus.rs        = r_rs;
    assign bus.rt        = r_rt;
    assign bus.wb_addr   = r_wbAddr;
    assign bus.shamt     = r_shamt;
    assign bus.imm       = r_imm;
    assign bus.sext      = r_sext;
    assign bus.alu_op    = r_aluOp;
    assign bus.reg_write = r_regWrite;
    assign bus.mem_read  = r_memRead;
    assign bus.mem_write = r_memWrite;
    assign bus.branch_eq = r_branchEq;
    assign bus.branch_ne = r_branchNe;
    assign bus.jump      = r_jump;
    assign bus.jump_reg  = r_jumpReg;
    assign bus.jidx      = r_jidx;
    assign bus.illegal   = r_illegal;

endmodule

// File: tb/tb_id_decode.sv
// tb_id_decode: table-driven bench for the decode stage. Every beat that
// the handshake accepts pushes its expected decode onto a scoreboard queue;
// a negedge monitor compares the held output against the queue head on
// every cycle and pops it when execute consumes it.
module tb_id_decode;

    typedef struct {
        logic [31:0] instr;
        logic [4:0]  wbAddr;
        logic        chkWb;
        logic [3:0]  aluOp;
        logic        chkAlu;
        logic        sext;
        logic        regWrite;
        logic        memRead;
        logic        memWrite;
        logic        branchEq;
        logic        branchNe;
        logic        jump;
        logic        jumpReg;
        logic        illegal;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        vec_t        v;
    } exp_t;

    localparam int NUM_VECS = 31;
    localparam int V_ADD    = 0;
    localparam int V_SUB    = 2;
    localparam int V_ADDI   = 15;
    localparam int V_LW     = 19;
    localparam int V_ORI    = 24;
    localparam int V_JAL    = 27;

    logic clk = 1'b0;
    logic rst_n;

    vec_t vecs [NUM_VECS];
    exp_t sbQ[$];
    exp_t curExp;
    int   checks = 0;
    int   errors = 0;

    id_decode_if #(.IMM_WIDTH(16)) bus ();

    id_decode #(.IMM_WIDTH(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // Free-running clock, 10 time units per period
    always #5 clk = ~clk;

    function automatic vec_t mkVec(input logic [31:0] instr, input logic [4:0] wb,
                                   input logic chkWb, input logic [3:0] alu,
                                   input logic chkAlu, input logic [8:0] f);
        vec_t v;
        v.instr  = instr;
        v.wbAddr = wb;
        v.chkWb  = chkWb;
        v.aluOp  = alu;
        v.chkAlu = chkAlu;
        {v.sext, v.regWrite, v.memRead, v.memWrite, v.branchEq,
         v.branchNe, v.jump, v.jumpReg, v.illegal} = f;
        return v;
    endfunction

    task automatic checkField(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Compare the held decode against one expected record
    task automatic compareExp(input exp_t e);
        checkField("out_pc",    bus.out_pc, e.pc);
        checkField("rs",        32'(bus.rs), 32'(e.v.instr[25:21]));
        checkField("rt",        32'(bus.rt), 32'(e.v.instr[20:16]));
        checkField("shamt",     32'(bus.shamt), 32'(e.v.instr[10:6]));
        checkField("imm",       32'(bus.imm), 32'(e.v.instr[15:0]));
        checkField("jidx",      32'(bus.jidx), 32'(e.v.instr[25:0]));
        if (e.v.chkWb)    checkField("wb_addr", 32'(bus.wb_addr), 32'(e.v.wbAddr));
        if (e.v.chkAlu)   checkField("alu_op",  32'(bus.alu_op), 32'(e.v.aluOp));
        if (!e.v.illegal) checkField("sext",    32'(bus.sext), 32'(e.v.sext));
        checkField("reg_write", 32'(bus.reg_write), 32'(e.v.regWrite));
        checkField("mem_read",  32'(bus.mem_read), 32'(e.v.memRead));
        checkField("mem_write", 32'(bus.mem_write), 32'(e.v.memWrite));
        checkField("branch_eq", 32'(bus.branch_eq), 32'(e.v.branchEq));
        checkField("branch_ne", 32'(bus.branch_ne), 32'(e.v.branchNe));
        checkField("jump",      32'(bus.jump), 32'(e.v.jump));
        checkField("jump_reg",  32'(bus.jump_reg), 32'(e.v.jumpReg));
        checkField("illegal",   32'(bus.illegal), 32'(e.v.illegal));
    endtask

    // Drive one cycle of fetch/execute inputs just after the rising edge
    task automatic applyStimulus(input logic valid, input logic [31:0] pc, input vec_t v,
                                 input logic fl, input logic rdy);
        @(posedge clk);
        #1;
        bus.in_valid  = valid;
        bus.in_pc     = pc;
        bus.in_instr  = v.instr;
        bus.flush     = fl;
        bus.out_ready = rdy;
        curExp.pc     = pc;
        curExp.v      = v;
    endtask

    // Check handshake outputs at the falling edge of the current cycle
    task automatic checkOutput(input string name, input logic expValid, input logic expReady);
        @(negedge clk);
        checkField({name, " out_valid"}, 32'(bus.out_valid), 32'(expValid));
        checkField({name, " in_ready"},  32'(bus.in_ready),  32'(expReady));
    endtask

    // Every output register must read zero after a reset
    task automatic checkResetState(input string name);
        checkField({name, " out_pc"},  bus.out_pc, 32'h0);
        checkField({name, " fields"},
                   32'({bus.rs, bus.rt, bus.wb_addr, bus.shamt}), 32'h0);
        checkField({name, " imm"},     32'(bus.imm), 32'h0);
        checkField({name, " jidx"},    32'(bus.jidx), 32'h0);
        checkField({name, " alu_op"},  32'(bus.alu_op), 32'h0);
        checkField({name, " controls"},
                   32'({bus.sext, bus.reg_write, bus.mem_read, bus.mem_write,
                        bus.branch_eq, bus.branch_ne, bus.jump, bus.jump_reg,
                        bus.illegal}), 32'h0);
    endtask

    // Scoreboard monitor: compare the head while valid, then pop/push per handshake
    always @(negedge clk) begin
        if (!rst_n) begin
            sbQ.delete();
        end else begin
            checkField("in_ready rule", 32'(bus.in_ready), 32'(!bus.out_valid || bus.out_ready));
            checkField("sb depth", 32'(bus.out_valid), 32'(sbQ.size() != 0));
            if (bus.out_valid && sbQ.size() != 0) compareExp(sbQ[0]);
            if (bus.flush) begin
                sbQ.delete();
            end else begin
                if (bus.out_valid && bus.out_ready && sbQ.size() != 0) sbQ.delete(0);
                if (bus.in_valid && (!bus.out_valid || bus.out_ready)) sbQ.push_back(curExp);
            end
        end
    end

    // Last-resort bound on simulation time
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main stimulus sequence
    initial begin
        vec_t idle;
        logic accepted;
        logic rdy;
        int   guard;

        vecs[0]  = mkVec(32'h012A5820, 5'd11, 1'b1, 4'd0,  1'b1, 9'b010000000); // add
        vecs[1]  = mkVec(32'h012A5821, 5'd11, 1'b1, 4'd0,  1'b1, 9'b010000000); // addu
        vecs[2]  = mkVec(32'h012A5822, 5'd11, 1'b1, 4'd1,  1'b1, 9'b010000000); // sub
        vecs[3]  = mkVec(32'h012A5823, 5'd11, 1'b1, 4'd1,  1'b1, 9'b010000000); // subu
        vecs[4]  = mkVec(32'h012A5824, 5'd11, 1'b1, 4'd2,  1'b1, 9'b010000000); // and
        vecs[5]  = mkVec(32'h012A5825, 5'd11, 1'b1, 4'd3,  1'b1, 9'b010000000); // or
        vecs[6]  = mkVec(32'h012A5826, 5'd11, 1'b1, 4'd4,  1'b1, 9'b010000000); // xor
        vecs[7]  = mkVec(32'h012A5827, 5'd11, 1'b1, 4'd5,  1'b1, 9'b010000000); // nor
        vecs[8]  = mkVec(32'h012A582A, 5'd11, 1'b1, 4'd6,  1'b1, 9'b010000000); // slt
        vecs[9]  = mkVec(32'h012A582B, 5'd11, 1'b1, 4'd7,  1'b1, 9'b010000000); // sltu
        vecs[10] = mkVec(32'h000A5880, 5'd11, 1'b1, 4'd8,  1'b1, 9'b010000000); // sll
        vecs[11] = mkVec(32'h000A5882, 5'd11, 1'b1, 4'd9,  1'b1, 9'b010000000); // srl
        vecs[12] = mkVec(32'h000A5883, 5'd11, 1'b1, 4'd10, 1'b1, 9'b010000000); // sra
        vecs[13] = mkVec(32'h03E00008, 5'd0,  1'b1, 4'd0,  1'b0, 9'b000000010); // jr
        vecs[14] = mkVec(32'h00000000, 5'd0,  1'b1, 4'd8,  1'b1, 9'b010000000); // nop
        vecs[15] = mkVec(32'h2008FFFF, 5'd8,  1'b1, 4'd0,  1'b1, 9'b110000000); // addi
        vecs[16] = mkVec(32'h2409FFFF, 5'd9,  1'b1, 4'd0,  1'b1, 9'b110000000); // addiu
        vecs[17] = mkVec(32'h290A0005, 5'd10, 1'b1, 4'd6,  1'b1, 9'b110000000); // slti
        vecs[18] = mkVec(32'h2D0A0005, 5'd10, 1'b1, 4'd7,  1'b1, 9'b110000000); // sltiu
        vecs[19] = mkVec(32'h8D0A0004, 5'd10, 1'b1, 4'd0,  1'b1, 9'b111000000); // lw
        vecs[20] = mkVec(32'hAD0A0004, 5'd10, 1'b1, 4'd0,  1'b1, 9'b100100000); // sw
        vecs[21] = mkVec(32'h110AFFFE, 5'd10, 1'b1, 4'd1,  1'b1, 9'b100010000); // beq
        vecs[22] = mkVec(32'h150AFFFE, 5'd10, 1'b1, 4'd1,  1'b1, 9'b100001000); // bne
        vecs[23] = mkVec(32'h3109FFFF, 5'd9,  1'b1, 4'd2,  1'b1, 9'b010000000); // andi
        vecs[24] = mkVec(32'h3409FFFF, 5'd9,  1'b1, 4'd3,  1'b1, 9'b010000000); // ori
        vecs[25] = mkVec(32'h3909FFFF, 5'd9,  1'b1, 4'd4,  1'b1, 9'b010000000); // xori
        vecs[26] = mkVec(32'h3C09ABCD, 5'd9,  1'b1, 4'd11, 1'b1, 9'b010000000); // lui
        vecs[27] = mkVec(32'h0C000010, 5'd31, 1'b1, 4'd0,  1'b0, 9'b010000100); // jal
        vecs[28] = mkVec(32'h08000100, 5'd0,  1'b0, 4'd0,  1'b0, 9'b000000100); // j
        vecs[29] = mkVec(32'hFC000000, 5'd0,  1'b0, 4'd0,  1'b0, 9'b000000001); // bad opcode
        vecs[30] = mkVec(32'h0000003F, 5'd0,  1'b0, 4'd0,  1'b0, 9'b000000001); // bad funct
        idle = vecs[14];

        // Reset held two edges while fetch offers an instruction
        rst_n         = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_pc     = 32'h0000_1234;
        bus.in_instr  = vecs[V_ADDI].instr;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        curExp.pc     = 32'h0000_1234;
        curExp.v      = vecs[V_ADDI];
        repeat (2) @(posedge clk);
        #1;
        rst_n        = 1'b1;
        bus.in_valid = 1'b0;
        checkOutput("reset", 1'b0, 1'b1);
        checkResetState("reset");

        // Back-to-back stream, one cycle latency each
        $display("[TB] stream addi/ori/lw");
        applyStimulus(1'b1, 32'h100, vecs[V_ADDI], 1'b0, 1'b1);
        checkOutput("streamLatency", 1'b0, 1'b1);
        applyStimulus(1'b1, 32'h104, vecs[V_ORI], 1'b0, 1'b1);
        checkOutput("streamAddi", 1'b1, 1'b1);
        checkField("streamAddi sext", 32'(bus.sext), 32'h1);
        checkField("streamAddi imm", 32'(bus.imm), 32'hFFFF);
        checkField("streamAddi wb_addr", 32'(bus.wb_addr), 32'd8);
        applyStimulus(1'b1, 32'h108, vecs[V_LW], 1'b0, 1'b1);
        checkOutput("streamOri", 1'b1, 1'b1);
        checkField("streamOri sext", 32'(bus.sext), 32'h0);
        checkField("streamOri wb_addr", 32'(bus.wb_addr), 32'd9);
        applyStimulus(1'b0, 32'h0, idle, 1'b0, 1'b1);
        checkOutput("streamLw", 1'b1, 1'b1);
        checkField("streamLw mem_read", 32'(bus.mem_read), 32'h1);
        checkField("streamLw sext", 32'(bus.sext), 32'h1);
        applyStimulus(1'b0, 32'h0, idle, 1'b0, 1'b1);
        checkOutput("streamDrained", 1'b0, 1'b1);

        // Backpressure: three stalled cycles, then release with no bubble
        $display("[TB] backpressure");
        applyStimulus(1'b1, 32'h200, vecs[V_ADD], 1'b0, 1'b0);
        checkOutput("bpLoad", 1'b0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b1, 32'h204, vecs[V_SUB], 1'b0, 1'b0);
            checkOutput("bpStall", 1'b1, 1'b0);
            checkField("bpStall out_pc", bus.out_pc, 32'h200);
        end
        applyStimulus(1'b1, 32'h204, vecs[V_SUB], 1'b0, 1'b1);
        checkOutput("bpRelease", 1'b1, 1'b1);
        applyStimulus(1'b0, 32'h0, idle, 1'b0, 1'b1);
        checkOutput("bpNoGap", 1'b1, 1'b1);
        checkField("bpNoGap out_pc", bus.out_pc, 32'h204);
        applyStimulus(1'b0, 32'h0, idle, 1'b0, 1'b1);
        checkOutput("bpDrained", 1'b0, 1'b1);

        // Flush while holding jal and offering add
        $display("[TB] flush");
        applyStimulus(1'b1, 32'h300, vecs[V_JAL], 1'b0, 1'b0);
        checkOutput("flushLoadJal", 1'b0, 1'b1);
        applyStimulus(1'b1, 32'h304, vecs[V_ADD], 1'b1, 1'b0);
        checkOutput("flushHoldJal", 1'b1, 1'b0);
        applyStimulus(1'b0, 32'h0, idle, 1'b0, 1'b0);
        checkOutput("flushBubble", 1'b0, 1'b1);
        // Flush while empty: the offered add would be accepted but must drop
        applyStimulus(1'b1, 32'h308, vecs[V_ADD], 1'b1, 1'b1);
        checkOutput("flushDropOffer", 1'b0, 1'b1);
        applyStimulus(1'b0, 32'h0, idle, 1'b0, 1'b1);
        checkOutput("flushNoAdd", 1'b0, 1'b1);

        // Decode table under random execute backpressure
        $display("[TB] decode table");
        for (int i = 0; i < NUM_VECS; i++) begin
            accepted = 1'b0;
            guard    = 0;
            while (!accepted && guard < 50) begin
                rdy = ($urandom_range(0, 3) != 0);
                applyStimulus(1'b1, 32'h400 + 32'(i * 4), vecs[i], 1'b0, rdy);
                @(negedge clk);
                accepted = !bus.out_valid || bus.out_ready;
                guard++;
            end
            if (!accepted) checkField("tableAccept timeout", 32'h0, 32'h1);
        end
        applyStimulus(1'b0, 32'h0, idle, 1'b0, 1'b1);
        applyStimulus(1'b0, 32'h0, idle, 1'b0, 1'b1);
        checkOutput("tableDrained", 1'b0, 1'b1);

        // Reset in the middle of a stall discards the held beat
        $display("[TB] reset mid-stall");
        applyStimulus(1'b1, 32'h500, vecs[V_LW], 1'b0, 1'b0);
        checkOutput("rstLoad", 1'b0, 1'b1);
        applyStimulus(1'b1, 32'h504, vecs[V_ADD], 1'b0, 1'b0);
        checkOutput("rstStall", 1'b1, 1'b0);
        applyStimulus(1'b1, 32'h508, vecs[V_ADD], 1'b0, 1'b0);
        rst_n = 1'b0;
        applyStimulus(1'b0, 32'h0, idle, 1'b0, 1'b0);
        rst_n = 1'b1;
        checkOutput("rstRecover", 1'b0, 1'b1);
        checkResetState("rstRecover");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
